// File: rtl/sr_ff_bank.sv
// sr_ff_bank: bank of WIDTH independent clocked SR flip-flops with per-channel
// enable, a defined S=R=1 resolution (no X), sticky per-channel conflict flags,
// a saturating conflict counter and registered rise/fall edge pulses.
// Every output comes from a register, so no input reaches an output combinationally.
module sr_ff_bank #(
  parameter int               WIDTH         = 8,
  parameter int               CONFLICT_MODE = 0,
  parameter int               CNT_W         = 8,
  parameter logic [WIDTH-1:0] RST_VAL       = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_status,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] conflict_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  // Popcount plus running total get enough headroom that the sum can never
  // wrap before the saturation compare.
  localparam int              POP_W   = $clog2(WIDTH + 1);
  localparam int              SUM_W   = CNT_W + POP_W;
  localparam logic [SUM_W-1:0] CNT_MAX = {{POP_W{1'b0}}, {CNT_W{1'b1}}};

  // S=R=1 resolution codes
  localparam logic [1:0] MODE_HOLD   = 2'd0;
  localparam logic [1:0] MODE_SET    = 2'd1;
  localparam logic [1:0] MODE_RESET  = 2'd2;
  localparam logic [1:0] MODE_TOGGLE = 2'd3;
  localparam logic [1:0] MODE        = CONFLICT_MODE[1:0];

  // Reject parameter sets the bank cannot implement.
  if (WIDTH < 1 || CNT_W < 2 || CONFLICT_MODE < 0 || CONFLICT_MODE > 3) begin : g_bad_param
    $error("sr_ff_bank: illegal parameter set");
  end

  // Per-channel conflict flags feed both the sticky bits and the counter.
  logic [WIDTH-1:0] conflict;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    logic ch_q_reg;
    logic ch_qbar_reg;
    logic ch_rise_reg;
    logic ch_fall_reg;
    logic ch_sticky_reg;
    logic ch_q_next;

    assign conflict[gi] = en[gi] & s[gi] & r[gi];

    // Next state of the SR cell; a disabled channel always holds.
    always_comb begin
      ch_q_next = ch_q_reg;
      if (en[gi]) begin
        case ({s[gi], r[gi]})
          2'b01:   ch_q_next = 1'b0;
          2'b10:   ch_q_next = 1'b1;
          2'b11: begin
            case (MODE)
              MODE_HOLD:   ch_q_next = ch_q_reg;
              MODE_SET:    ch_q_next = 1'b1;
              MODE_RESET:  ch_q_next = 1'b0;
              MODE_TOGGLE: ch_q_next = ~ch_q_reg;
              default:     ch_q_next = ch_q_reg;
            endcase
          end
          default: ch_q_next = ch_q_reg;
        endcase
      end
    end

    // State, complement and edge pulses all register together so qbar is
    // always ~q and a pulse lines up with the q edge it reports.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ch_q_reg    <= RST_VAL[gi];
        ch_qbar_reg <= ~RST_VAL[gi];
        ch_rise_reg <= 1'b0;
        ch_fall_reg <= 1'b0;
      end else begin
        ch_q_reg    <= ch_q_next;
        ch_qbar_reg <= ~ch_q_next;
        ch_rise_reg <= ch_q_next & ~ch_q_reg;
        ch_fall_reg <= ~ch_q_next & ch_q_reg;
      end
    end

    // Sticky conflict flag; a new conflict beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ch_sticky_reg <= 1'b0;
      end else begin
        ch_sticky_reg <= conflict[gi] | (ch_sticky_reg & ~clr_status);
      end
    end

    assign q[gi]               = ch_q_reg;
    assign qbar[gi]            = ch_qbar_reg;
    assign rise_pulse[gi]      = ch_rise_reg;
    assign fall_pulse[gi]      = ch_fall_reg;
    assign conflict_sticky[gi] = ch_sticky_reg;
  end

  logic [SUM_W-1:0] pop_next;
  logic [SUM_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_reg;

  // Count this cycle's conflicts across all channels.
  always_comb begin
    pop_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_next = pop_next + SUM_W'(conflict[i]);
    end
  end

  // Clear drops the old total but still counts the same-cycle conflicts;
  // the widened sum is clamped instead of wrapping.
  always_comb begin
    sum_next = (clr_status ? '0 : {{POP_W{1'b0}}, cnt_reg}) + pop_next;
    cnt_next = (sum_next > CNT_MAX) ? {CNT_W{1'b1}} : sum_next[CNT_W-1:0];
  end

  // Saturating conflict counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign conflict_cnt = cnt_reg;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: four 8-bit instances (one per conflict mode, 8-bit
// counter) plus a mode-0 instance with a 4-bit counter, all on shared inputs.
// A per-instance behavioural model is compared every cycle; directed steps
// add literal expectations.
module tb_sr_ff_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] en  = '0;
  logic [7:0] s   = '0;
  logic [7:0] r   = '0;
  logic       clr = 1'b0;

  logic [7:0] dq    [5];
  logic [7:0] dqb   [5];
  logic [7:0] drise [5];
  logic [7:0] dfall [5];
  logic [7:0] dst   [5];
  logic [7:0] dcnt  [5];
  logic [3:0] cnt_sat;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_on = 1'b0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(gi), .CNT_W(8), .RST_VAL(8'h00)) u_dut (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_status(clr),
      .q(dq[gi]), .qbar(dqb[gi]), .rise_pulse(drise[gi]), .fall_pulse(dfall[gi]),
      .conflict_sticky(dst[gi]), .conflict_cnt(dcnt[gi]));
  end

  sr_ff_bank #(.WIDTH(8), .CONFLICT_MODE(0), .CNT_W(4), .RST_VAL(8'h00)) u_sat (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_status(clr),
    .q(dq[4]), .qbar(dqb[4]), .rise_pulse(drise[4]), .fall_pulse(dfall[4]),
    .conflict_sticky(dst[4]), .conflict_cnt(cnt_sat));
  assign dcnt[4] = {4'h0, cnt_sat};

  // ---------------- behavioural model ----------------
  logic [7:0] mq    [5];
  logic [7:0] mrise [5];
  logic [7:0] mfall [5];
  logic [7:0] mst   [5];
  int         mcnt  [5];

  function automatic int mode_of(int m);
    return (m < 4) ? m : 0;
  endfunction

  function automatic int cmax_of(int m);
    return (m < 4) ? 255 : 15;
  endfunction

  function automatic logic [7:0] model_next(int mode, logic [7:0] cur,
                                           logic [7:0] e, logic [7:0] sv, logic [7:0] rv);
    logic [7:0] nq;
    nq = cur;
    for (int b = 0; b < 8; b++) begin
      if (e[b]) begin
        if (sv[b] && !rv[b]) nq[b] = 1'b1;
        else if (!sv[b] && rv[b]) nq[b] = 1'b0;
        else if (sv[b] && rv[b]) begin
          if (mode == 1) nq[b] = 1'b1;
          else if (mode == 2) nq[b] = 1'b0;
          else if (mode == 3) nq[b] = ~cur[b];
        end
      end
    end
    return nq;
  endfunction

  function automatic int conflicts(logic [7:0] e, logic [7:0] sv, logic [7:0] rv);
    int c;
    c = 0;
    for (int b = 0; b < 8; b++) if (e[b] && sv[b] && rv[b]) c++;
    return c;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < 5; m++) begin
        mq[m] <= 8'h00; mrise[m] <= 8'h00; mfall[m] <= 8'h00;
        mst[m] <= 8'h00; mcnt[m] <= 0;
      end
    end else begin
      for (int m = 0; m < 5; m++) begin
        logic [7:0] nq;
        int total;
        nq    = model_next(mode_of(m), mq[m], en, s, r);
        total = (clr ? 0 : mcnt[m]) + conflicts(en, s, r);
        mq[m]    <= nq;
        mrise[m] <= nq & ~mq[m];
        mfall[m] <= ~nq & mq[m];
        mst[m]   <= (clr ? 8'h00 : mst[m]) | (en & s & r);
        mcnt[m]  <= (total > cmax_of(m)) ? cmax_of(m) : total;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (check_on) begin
      for (int m = 0; m < 5; m++) begin
        check($sformatf("m%0d q", m),      {24'h0, dq[m]},    {24'h0, mq[m]});
        check($sformatf("m%0d qbar", m),   {24'h0, dqb[m]},   {24'h0, ~mq[m]});
        check($sformatf("m%0d rise", m),   {24'h0, drise[m]}, {24'h0, mrise[m]});
        check($sformatf("m%0d fall", m),   {24'h0, dfall[m]}, {24'h0, mfall[m]});
        check($sformatf("m%0d sticky", m), {24'h0, dst[m]},   {24'h0, mst[m]});
        check($sformatf("m%0d cnt", m),    {24'h0, dcnt[m]},  mcnt[m]);
      end
    end
  end

  // Drive one input vector after the falling edge, then land just past the rising edge.
  task automatic step(input logic [7:0] e, input logic [7:0] sv, input logic [7:0] rv,
                      input logic c);
    @(negedge clk);
    #1;
    en = e; s = sv; r = rv; clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_on = 1'b1;
    check("reset q", {24'h0, dq[0]}, 32'h00);
    check("reset qbar", {24'h0, dqb[0]}, 32'hFF);
    check("reset cnt", {24'h0, dcnt[0]}, 32'h0);
    @(negedge clk); #1; rst = 1'b1;

    // T2 basic set / reset / hold
    step(8'hFF, 8'h0F, 8'h00, 1'b0);
    check("T2 set q", {24'h0, dq[0]}, 32'h0F);
    check("T2 set rise", {24'h0, drise[0]}, 32'h0F);
    step(8'hFF, 8'h00, 8'h03, 1'b0);
    check("T2 rst q", {24'h0, dq[0]}, 32'h0C);
    check("T2 rst fall", {24'h0, dfall[0]}, 32'h03);
    check("T2 rst rise", {24'h0, drise[0]}, 32'h00);
    step(8'hFF, 8'h00, 8'h00, 1'b0);
    check("T2 hold q", {24'h0, dq[0]}, 32'h0C);
    check("T2 hold fall", {24'h0, dfall[0]}, 32'h00);

    // T3 conflict on ch0 from q[0]=0, three edges
    for (int k = 0; k < 3; k++) begin
      step(8'hFF, 8'h01, 8'h01, 1'b0);
      check($sformatf("T3 mode0 q0 e%0d", k), {31'h0, dq[0][0]}, 32'd0);
      check($sformatf("T3 mode1 q0 e%0d", k), {31'h0, dq[1][0]}, 32'd1);
      check($sformatf("T3 mode2 q0 e%0d", k), {31'h0, dq[2][0]}, 32'd0);
      check($sformatf("T3 mode3 q0 e%0d", k), {31'h0, dq[3][0]}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("T3 mode3 rise e%0d", k), {31'h0, drise[3][0]}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("T3 mode3 fall e%0d", k), {31'h0, dfall[3][0]}, (k % 2 == 0) ? 32'd0 : 32'd1);
    end
    check("T3 sticky", {24'h0, dst[0]}, 32'h01);
    check("T3 cnt", {24'h0, dcnt[0]}, 32'd3);
    step(8'hFF, 8'h00, 8'h00, 1'b1);
    check("T3 clr sticky", {24'h0, dst[0]}, 32'h00);
    check("T3 clr cnt", {24'h0, dcnt[0]}, 32'd0);

    // T4 partial enable
    step(8'hF0, 8'hFF, 8'hFF, 1'b0);
    check("T4 q", {24'h0, dq[0]}, 32'h0C);
    check("T4 cnt1", {24'h0, dcnt[0]}, 32'd4);
    check("T4 sticky", {24'h0, dst[0]}, 32'hF0);
    check("T4 mode1 q", {24'h0, dq[1]}, 32'hFD);
    step(8'hF0, 8'hFF, 8'hFF, 1'b0);
    check("T4 cnt2", {24'h0, dcnt[0]}, 32'd8);
    step(8'h00, 8'h00, 8'h00, 1'b1);

    // T5 saturation of the 4-bit counter
    step(8'hFF, 8'hFF, 8'hFF, 1'b0);
    check("T5 sat cnt1", {24'h0, dcnt[4]}, 32'd8);
    step(8'hFF, 8'hFF, 8'hFF, 1'b0);
    check("T5 sat cnt2", {24'h0, dcnt[4]}, 32'd15);
    check("T5 wide cnt2", {24'h0, dcnt[0]}, 32'd16);
    step(8'hFF, 8'hFF, 8'hFF, 1'b0);
    check("T5 sat cnt3", {24'h0, dcnt[4]}, 32'd15);
    check("T5 wide cnt3", {24'h0, dcnt[0]}, 32'd24);

    // T6 clear racing a new conflict on ch2
    step(8'hFF, 8'h04, 8'h04, 1'b1);
    check("T6 sticky", {24'h0, dst[0]}, 32'h04);
    check("T6 cnt", {24'h0, dcnt[0]}, 32'd1);
    check("T6 sat cnt", {24'h0, dcnt[4]}, 32'd1);

    // T1 asynchronous reset mid-run from q=FF
    step(8'hFF, 8'hFF, 8'h00, 1'b0);
    check("T1 pre q", {24'h0, dq[0]}, 32'hFF);
    @(negedge clk); #1;
    en = 8'h00; s = 8'h00; r = 8'h00;
    rst = 1'b0;
    #1;
    check("T1 async q", {24'h0, dq[0]}, 32'h00);
    check("T1 async qbar", {24'h0, dqb[0]}, 32'hFF);
    check("T1 async cnt", {24'h0, dcnt[0]}, 32'd0);
    check("T1 async sticky", {24'h0, dst[0]}, 32'h00);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("T1 release rise", {24'h0, drise[0]}, 32'h00);
    check("T1 release fall", {24'h0, dfall[0]}, 32'h00);
    check("T1 release q", {24'h0, dq[0]}, 32'h00);
    step(8'hFF, 8'hFF, 8'h00, 1'b0);
    check("T1 post rise", {24'h0, drise[0]}, 32'hFF);
    step(8'h00, 8'h00, 8'h00, 1'b0);
    check("T1 pulse ends", {24'h0, drise[0]}, 32'h00);

    @(negedge clk);
    #1;
    check_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
